image_write_scheduler: RTL and testbench

// - Shares the single write port of the 160x120x3 image RAM among NUM_REQ drawing clients (player, obstacle, eraser).
// - Round-robin arbitration with a one-pixel-per-cycle valid/ready handshake per client.
// - Built-in clear sequencer sweeps the whole frame with CLEAR_COLOR; it has priority over all clients.
// - Sits between the game-logic drawers and the image RAM write side (x_write/y_write/color_in/wren).

---
 rtl/image_ram_pkg.sv | 17 +
 rtl/image_write_scheduler_rr_arbiter.sv | 40 ++++
 rtl/image_write_scheduler.sv | 163 ++++++++++++++++
 tb/tb_image_write_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/image_ram_pkg.sv
// Shared widths, default frame limits and scheduler state encoding for the
// 160x120x3 image RAM write path.
package image_ram_pkg;

   localparam int X_W     = 8;
   localparam int Y_W     = 7;
   localparam int COLOR_W = 3;

   localparam int X_MAX_DEF = 159;
   localparam int Y_MAX_DEF = 119;

   typedef enum logic {
      S_ARB   = 1'b0,
      S_CLEAR = 1'b1
   } sched_state_t;

endpackage

// File: rtl/image_write_scheduler_rr_arbiter.sv
// Purely combinational round-robin arbiter: grants the first requester at or
// after the pointer (wrapping) and reports the pointer that follows the winner.
module rr_arbiter
#(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [PTR_W-1:0]   o_nextPtr
);

   logic [PTR_W:0]   w_sum;
   logic [PTR_W-1:0] w_idx;
   logic             w_found;

   // Walk the requesters starting at the pointer; the extra sum bit keeps the
   // wrap-around subtraction exact for any NUM_REQ.
   always_comb begin
      o_gnt     = '0;
      o_nextPtr = i_ptr;
      w_found   = 1'b0;
      w_sum     = '0;
      w_idx     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_sum = {1'b0, i_ptr} + (PTR_W+1)'(i);
         if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
         end
         w_idx = w_sum[PTR_W-1:0];
         if (!w_found && i_req[w_idx]) begin
            w_found      = 1'b1;
            o_gnt[w_idx] = 1'b1;
            o_nextPtr    = (w_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_idx + PTR_W'(1);
         end
      end
   end

endmodule

// File: rtl/image_write_scheduler.sv
// Shares the image RAM write port among drawing clients (round robin) and runs
// a prioritised full-frame clear sweep. Optional macro: WRITE_IN_BLANK_EN.
module image_write_scheduler
   import image_ram_pkg::*;
#(
   parameter int                 NUM_REQ     = 3,
   parameter int                 X_MAX       = X_MAX_DEF,
   parameter int                 Y_MAX       = Y_MAX_DEF,
   parameter logic [COLOR_W-1:0] CLEAR_COLOR = 3'b000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [X_W*NUM_REQ-1:0]       req_x,
   input  logic [Y_W*NUM_REQ-1:0]       req_y,
   input  logic [COLOR_W*NUM_REQ-1:0]   req_color,
   output logic [NUM_REQ-1:0]           gnt,
   input  logic                         clear_start,
   output logic                         clear_busy,
   output logic                         clear_done,
   input  logic                         vga_blank,
   output logic [X_W-1:0]               x_write,
   output logic [Y_W-1:0]               y_write,
   output logic [COLOR_W-1:0]           color_in,
   output logic                         wren
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   sched_state_t r_state, w_nextState;

   logic [PTR_W-1:0]   r_rrPtr, w_nextPtr;
   logic [X_W-1:0]     r_clearX, r_xWrite, w_winX;
   logic [Y_W-1:0]     r_clearY, r_yWrite, w_winY;
   logic [COLOR_W-1:0] r_color, w_winColor;
   logic               r_wren, r_clearDone;
   logic               w_allow, w_lastPixel;
   logic [NUM_REQ-1:0] w_arbReq, w_arbGnt;

   logic [NUM_REQ-1:0][X_W-1:0]     w_reqX;
   logic [NUM_REQ-1:0][Y_W-1:0]     w_reqY;
   logic [NUM_REQ-1:0][COLOR_W-1:0] w_reqColor;

   assign w_reqX     = req_x;
   assign w_reqY     = req_y;
   assign w_reqColor = req_color;

`ifdef WRITE_IN_BLANK_EN
   assign w_allow = vga_blank;
`else
   logic w_unusedBlank;
   assign w_unusedBlank = vga_blank;
   assign w_allow       = 1'b1;
`endif

   assign w_lastPixel = (r_clearX == X_W'(X_MAX)) && (r_clearY == Y_W'(Y_MAX));

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .i_req     (w_arbReq),
      .i_ptr     (r_rrPtr),
      .o_gnt     (w_arbGnt),
      .o_nextPtr (w_nextPtr)
   );

   // Clients only compete in S_ARB when no clear is being launched.
   always_comb begin
      w_nextState = r_state;
      w_arbReq    = '0;
      case (r_state)
         S_ARB: begin
            if (clear_start) begin
               w_nextState = S_CLEAR;
            end else if (w_allow) begin
               w_arbReq = req;
            end
         end
         S_CLEAR: begin
            if (w_allow && w_lastPixel) begin
               w_nextState = S_ARB;
            end
         end
         default: w_nextState = S_ARB;
      endcase
   end

   always_comb begin
      w_winX     = r_xWrite;
      w_winY     = r_yWrite;
      w_winColor = r_color;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_arbGnt[i]) begin
            w_winX     = w_reqX[i];
            w_winY     = w_reqY[i];
            w_winColor = w_reqColor[i];
         end
      end
   end

   // Address/colour registers hold when idle; only wren and clear_done drop.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_ARB;
         r_rrPtr     <= '0;
         r_clearX    <= '0;
         r_clearY    <= '0;
         r_xWrite    <= '0;
         r_yWrite    <= '0;
         r_color     <= '0;
         r_wren      <= 1'b0;
         r_clearDone <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_wren      <= 1'b0;
         r_clearDone <= 1'b0;
         case (r_state)
            S_ARB: begin
               if (clear_start) begin
                  r_clearX <= '0;
                  r_clearY <= '0;
               end else if (|w_arbGnt) begin
                  r_rrPtr  <= w_nextPtr;
                  r_xWrite <= w_winX;
                  r_yWrite <= w_winY;
                  r_color  <= w_winColor;
                  r_wren   <= 1'b1;
               end
            end
            S_CLEAR: begin
               if (w_allow) begin
                  r_xWrite <= r_clearX;
                  r_yWrite <= r_clearY;
                  r_color  <= CLEAR_COLOR;
                  r_wren   <= 1'b1;
                  if (r_clearX == X_W'(X_MAX)) begin
                     r_clearX <= '0;
                     if (w_lastPixel) begin
                        r_clearY    <= '0;
                        r_clearDone <= 1'b1;
                     end else begin
                        r_clearY <= r_clearY + Y_W'(1);
                     end
                  end else begin
                     r_clearX <= r_clearX + X_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign gnt        = reset ? '0 : w_arbGnt;
   assign clear_busy = (r_state == S_CLEAR);
   assign clear_done = r_clearDone;
   assign x_write    = r_xWrite;
   assign y_write    = r_yWrite;
   assign color_in   = r_color;
   assign wren       = r_wren;

endmodule

// File: tb/tb_image_write_scheduler.sv
// Self-checking bench for image_write_scheduler: frame-level behavioural model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_image_write_scheduler;

   localparam int COLS   = 160;
   localparam int ROWS   = 120;
   localparam int PIXELS = COLS * ROWS;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  req = 3'b111;
   logic [23:0] reqX = {8'd21, 8'd11, 8'd1};
   logic [20:0] reqY = {7'd4, 7'd3, 7'd2};
   logic [8:0]  reqColor = {3'd3, 3'd2, 3'd1};
   logic        clearStart = 1'b0;
   logic        vgaBlank = 1'b1;
   logic [2:0]  gnt;
   logic        clearBusy, clearDone, wren;
   logic [7:0]  xWrite;
   logic [6:0]  yWrite;
   logic [2:0]  colorIn;

   int assertCount = 0;
   int failCount   = 0;

   image_write_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_x       (reqX),
      .req_y       (reqY),
      .req_color   (reqColor),
      .gnt         (gnt),
      .clear_start (clearStart),
      .clear_busy  (clearBusy),
      .clear_done  (clearDone),
      .vga_blank   (vgaBlank),
      .x_write     (xWrite),
      .y_write     (yWrite),
      .color_in    (colorIn),
      .wren        (wren)
   );

   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         if (failCount <= 30)
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] r, input logic cs);
      @(posedge clk);
      #1;
      req        = r;
      clearStart = cs;
   endtask

   // Blanking window generator: toggles every 100 cycles while enabled.
   bit blankToggleEn = 1'b0;
   int blankCnt = 0;
   always @(posedge clk) begin
      #1;
      if (blankToggleEn) begin
         blankCnt++;
         if (blankCnt == 100) begin
            blankCnt = 0;
            vgaBlank = ~vgaBlank;
         end
      end else begin
         blankCnt = 0;
         vgaBlank = 1'b1;
      end
   end

   // Frame-level model: clients ranked by "who was served last", clear as a
   // linear pixel index mapped to raster coordinates.
   int   mLastWinner = 2;
   bit   mClearing = 1'b0;
   int   mPix = 0;
   int   mWin;
   bit   mAllow;
   logic [2:0] expGnt;
   int   expX = 0, expY = 0, expC = 0;
   bit   expWren = 1'b0, expDone = 1'b0;

   always @(negedge clk) begin
      checkOutput("mWren", wren, expWren);
      checkOutput("mX", xWrite, expX);
      checkOutput("mY", yWrite, expY);
      checkOutput("mColor", colorIn, expC);
      checkOutput("mDone", clearDone, expDone);
      checkOutput("mBusy", clearBusy, mClearing);
      mAllow = 1'b1;
`ifdef WRITE_IN_BLANK_EN
      mAllow = vgaBlank;
`endif
      mWin   = -1;
      expGnt = 3'b000;
      if (!reset && !mClearing && !clearStart && mAllow) begin
         for (int i = 1; i <= 3; i++) begin
            if (mWin < 0 && req[(mLastWinner + i) % 3]) mWin = (mLastWinner + i) % 3;
         end
      end
      if (mWin >= 0) expGnt[mWin] = 1'b1;
      checkOutput("mGnt", gnt, expGnt);
      expDone = 1'b0;
      if (reset) begin
         mLastWinner = 2;
         mClearing   = 1'b0;
         expX = 0; expY = 0; expC = 0;
         expWren = 1'b0;
      end else if (mClearing) begin
         if (mAllow) begin
            expX = mPix % COLS;
            expY = mPix / COLS;
            expC = 0;
            expWren = 1'b1;
            mPix++;
            if (mPix == PIXELS) begin
               mClearing = 1'b0;
               expDone   = 1'b1;
            end
         end else begin
            expWren = 1'b0;
         end
      end else if (clearStart) begin
         mClearing = 1'b1;
         mPix      = 0;
         expWren   = 1'b0;
      end else if (mWin >= 0) begin
         expWren = 1'b1;
         expX = reqX[8*mWin +: 8];
         expY = reqY[7*mWin +: 7];
         expC = reqColor[3*mWin +: 3];
         mLastWinner = mWin;
      end else begin
         expWren = 1'b0;
      end
   end

   logic [2:0] rrSeq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
   int  writes;
   bit  done;

   initial begin
      // Reset held with all clients requesting.
      repeat (3) @(negedge clk);
      checkOutput("resetGnt", gnt, 0);
      checkOutput("resetWren", wren, 0);
      checkOutput("resetX", xWrite, 0);
      checkOutput("resetY", yWrite, 0);
      checkOutput("resetColor", colorIn, 0);
      checkOutput("resetBusy", clearBusy, 0);
      checkOutput("resetDone", clearDone, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Round robin with all three requesting; first grant goes to client 0.
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checkOutput("rrGnt", gnt, rrSeq[k]);
         if (k > 0) begin
            checkOutput("rrWren", wren, 1);
            checkOutput("rrX", xWrite, 10 * ((k - 1) % 3) + 1);
         end
      end

      // Single client 1 writing (10,20,5).
      applyStimulus(3'b000, 1'b0);
      reqX[15:8]    = 8'd10;
      reqY[13:7]    = 7'd20;
      reqColor[5:3] = 3'd5;
      applyStimulus(3'b010, 1'b0);
      @(negedge clk);
      checkOutput("singleGnt", gnt, 3'b010);
      applyStimulus(3'b000, 1'b0);
      @(negedge clk);
      checkOutput("singleX", xWrite, 10);
      checkOutput("singleY", yWrite, 20);
      checkOutput("singleColor", colorIn, 5);
      checkOutput("singleWren", wren, 1);
      @(negedge clk);
      checkOutput("idleWren", wren, 0);
      checkOutput("idleHoldX", xWrite, 10);

      // Full clear with every client requesting; a second start mid-sweep.
      applyStimulus(3'b111, 1'b1);
      @(negedge clk);
      checkOutput("clearStartGnt", gnt, 0);
      blankToggleEn = 1'b1;
      writes = 0;
      done   = 1'b0;
      for (int k = 0; k < 45000 && !done; k++) begin
         @(posedge clk);
         #1;
         if (k == 0 || k == 1000) clearStart = 1'b0;
         else if (k == 999) clearStart = 1'b1;
         @(negedge clk);
         if (wren) writes++;
         if (clearDone) begin
            done = 1'b1;
            checkOutput("clearLastX", xWrite, COLS - 1);
            checkOutput("clearLastY", yWrite, ROWS - 1);
            checkOutput("clearLastWren", wren, 1);
            checkOutput("clearBusyAtDone", clearBusy, 0);
         end
      end
      if (!done) checkOutput("clearDoneTimeout", 0, 1);
      checkOutput("clearWrites", writes, PIXELS);
      blankToggleEn = 1'b0;
      @(negedge clk);
      checkOutput("doneIsPulse", clearDone, 0);

      // Reset after 500 sweep pixels: aborted with no done pulse.
      applyStimulus(3'b000, 1'b1);
      applyStimulus(3'b000, 1'b0);
      writes = 0;
      for (int k = 0; k < 5000 && writes < 500; k++) begin
         @(negedge clk);
         if (wren) writes++;
      end
      checkOutput("abortReach500", writes, 500);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("abortWren", wren, 0);
      checkOutput("abortBusy", clearBusy, 0);
      checkOutput("abortDone", clearDone, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      done = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (clearDone) done = 1'b1;
      end
      checkOutput("abortNoDone", done, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
